// File: rtl/blink_ctrl.sv
// blink_ctrl: sequencer that toggles a switch output in timed bursts.
// Each blink is an on-phase followed by an off-phase, each lasting the
// half-period latched at start. A burst length of zero runs continuously.
// Optional build macro: BLINK_CTRL_RESTART_EN lets a start request issued
// while a burst is running re-latch the configuration and begin a fresh
// burst instead of being ignored.
//
// Handshake: i_start and i_stop are single-edge requests sampled on the
// rising edge of clk. i_stop has priority over i_start. o_busy is high
// while a burst runs. o_done pulses for one cycle only when a burst ends
// by reaching its blink count; an abort never raises o_done.
module blink_ctrl #(
    parameter int CNT_WIDTH   = 16,
    parameter int BURST_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [CNT_WIDTH-1:0]   i_half_period,
    input  logic [BURST_WIDTH-1:0] i_nblinks,
    output logic                   o_sw,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = 1;
    localparam logic [BURST_WIDTH-1:0] BURST_ONE = 1;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   hp;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [BURST_WIDTH-1:0] nb;
    logic [BURST_WIDTH-1:0] blink_cnt;

    logic [CNT_WIDTH-1:0]   hp_start;
    logic [CNT_WIDTH-1:0]   hp_last;
    logic [BURST_WIDTH-1:0] blink_next;
    logic                   phase_end;
    logic                   last_blink;

    // A zero half-period is treated as one cycle so the output still toggles.
    assign hp_start   = (i_half_period == '0) ? CNT_ONE : i_half_period;
    assign hp_last    = hp - CNT_ONE;
    assign phase_end  = (cnt == hp_last);
    assign blink_next = blink_cnt + BURST_ONE;
    assign last_blink = (nb != '0) && (blink_next == nb);

    // Two-state sequencer with registered switch/status outputs.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            hp        <= '0;
            nb        <= '0;
            cnt       <= '0;
            blink_cnt <= '0;
            o_sw      <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_sw   <= 1'b0;
                    o_busy <= 1'b0;
                    if (i_start && !i_stop) begin
                        hp        <= hp_start;
                        nb        <= i_nblinks;
                        cnt       <= '0;
                        blink_cnt <= '0;
                        o_sw      <= 1'b1;
                        o_busy    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        o_sw   <= 1'b0;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
`ifdef BLINK_CTRL_RESTART_EN
                    else if (i_start) begin
                        // Restart beats a coinciding completion flip.
                        hp        <= hp_start;
                        nb        <= i_nblinks;
                        cnt       <= '0;
                        blink_cnt <= '0;
                        o_sw      <= 1'b1;
                    end
`endif
                    else if (phase_end) begin
                        cnt  <= '0;
                        o_sw <= ~o_sw;
                        // A falling flip closes one blink.
                        if (o_sw) begin
                            blink_cnt <= blink_next;
                            if (last_blink) begin
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    o_sw   <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_ctrl.sv
// tb_blink_ctrl: directed and randomized checks of blink_ctrl against a
// time-based reference model (edges elapsed since start, divided into
// half-periods). Honours BLINK_CTRL_RESTART_EN the same way the design does.
module tb_blink_ctrl;

    localparam int CW = 16;
    localparam int BW = 4;
`ifdef BLINK_CTRL_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] half_period = '0;
    logic [BW-1:0] nblinks = '0;
    logic          sw;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: whether a burst is active, latched config,
    // and number of edges since the start edge.
    bit m_active = 1'b0;
    int m_hp = 1;
    int m_nb = 0;
    int m_k  = 0;
    bit m_done = 1'b0;

    blink_ctrl #(.CNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
        .clk           (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_stop        (stop),
        .i_half_period (half_period),
        .i_nblinks     (nblinks),
        .o_sw          (sw),
        .o_busy        (busy),
        .o_done        (done)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic void model_latch();
        m_hp   = (half_period == 0) ? 1 : int'(half_period);
        m_nb   = int'(nblinks);
        m_k    = 0;
    endfunction

    // Advance the model by one rising edge using the inputs of that edge.
    function automatic void model_edge();
        m_done = 1'b0;
        if (!m_active) begin
            if (start && !stop) begin
                model_latch();
                m_active = 1'b1;
            end
        end else if (stop) begin
            m_active = 1'b0;
        end else if (RESTART && start) begin
            model_latch();
        end else begin
            m_k = m_k + 1;
            if (m_nb != 0 && m_k == (2 * m_nb - 1) * m_hp) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        logic exp_sw;
        exp_sw = m_active && (((m_k / m_hp) % 2) == 0);
        n_checks++;
        assert (sw === exp_sw) else begin
            n_fails++;
            $error("FAIL %s sw: got %b expected %b", tag, sw, exp_sw);
        end
        n_checks++;
        assert (busy === logic'(m_active)) else begin
            n_fails++;
            $error("FAIL %s busy: got %b expected %b", tag, busy, m_active);
        end
        n_checks++;
        assert (done === logic'(m_done)) else begin
            n_fails++;
            $error("FAIL %s done: got %b expected %b", tag, done, m_done);
        end
    endtask

    // Drive one cycle's inputs, take the edge, then check just after it.
    task automatic cycle(input bit s, input bit p, input int hp, input int nb,
                         input string tag);
        start       = s;
        stop        = p;
        half_period = CW'(hp);
        nblinks     = BW'(nb);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, tag);
    endtask

    // Assert reset between edges and check outputs before any edge arrives.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        m_active = 1'b0;
        m_done   = 1'b0;
        m_k      = 0;
        check_outputs(tag);
        @(posedge clk);
        #1;
        check_outputs({tag, "_held"});
        rst = 1'b0;
    endtask

    initial begin
        // Power-on reset
        rst = 1'b1;
        #1;
        check_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2, "idle_after_por");

        // hp=3, nb=2: 3 high, 3 low, 3 high, then done on the final fall
        cycle(1'b1, 1'b0, 3, 2, "hp3_start");
        idle_cycles(12, "hp3_run");

        // hp=0 treated as 1, single blink
        cycle(1'b1, 1'b0, 0, 1, "hp0_start");
        idle_cycles(4, "hp0_run");

        // Continuous hp=2 for 20 cycles, then abort
        cycle(1'b1, 1'b0, 2, 0, "cont_start");
        idle_cycles(20, "cont_run");
        cycle(1'b0, 1'b1, 0, 0, "cont_stop");
        idle_cycles(3, "cont_after");

        // Start and stop together in IDLE: stop wins
        cycle(1'b1, 1'b1, 3, 2, "start_stop_idle");
        idle_cycles(2, "start_stop_after");

        // Start pulse during RUN with different config
        cycle(1'b1, 1'b0, 2, 2, "run_start");
        idle_cycles(2, "run_pre");
        cycle(1'b1, 1'b0, 5, 3, "run_start_again");
        idle_cycles(12, "run_post");

        // Config inputs wiggling during RUN must not matter
        cycle(1'b1, 1'b0, 2, 1, "cfg_start");
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 15), "cfg_wiggle");

        // Asynchronous reset mid-burst
        cycle(1'b1, 1'b0, 4, 3, "rst_start");
        idle_cycles(6, "rst_run");
        async_reset("rst_mid");
        idle_cycles(3, "rst_after");

        // Restart at edge 5 with hp=1 nb=1 (ignored without the restart build)
        cycle(1'b1, 1'b0, 2, 2, "rs_start");
        idle_cycles(4, "rs_run");
        cycle(1'b1, 1'b0, 1, 1, "rs_restart");
        idle_cycles(10, "rs_after");

        // Restart landing on a completion flip: hp=1 nb=1, start at edge 1
        cycle(1'b1, 1'b0, 1, 1, "rsc_start");
        cycle(1'b1, 1'b0, 2, 1, "rsc_restart");
        idle_cycles(6, "rsc_after");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit s, p;
            s = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 39) == 0);
            cycle(s, p, $urandom_range(0, 4), $urandom_range(0, 3), "rand");
        end
        idle_cycles(40, "rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
